// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr & 32'h0000_0003);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and memory.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_addr, output imem_req, input imem_rdata, input imem_ready);
    modport slave  (input imem_addr, input imem_req, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: jr > jump > taken branch > sequential.
module next_pc (
    input  logic               [31:0] i_pcplus4,
    input  logic               [25:0] i_target,
    input  logic signed        [31:0] i_signimm,
    input  logic               [31:0] i_rs_data,
    input  logic                      i_pcsrc,
    input  logic                      i_jump,
    input  logic                      i_jr,
    output logic               [31:0] o_npc
);
    logic signed [31:0] w_br_off;
    logic        [31:0] w_br_target;
    logic        [31:0] w_j_target;

    // Branch offset is a word count; the add wraps modulo 2^32.
    assign w_br_off    = i_signimm <<< 2;
    assign w_br_target = i_pcplus4 + $unsigned(w_br_off);
    assign w_j_target  = {i_pcplus4[31:28], i_target, 2'b00};

    always_comb begin
        if (i_jr)
            o_npc = i_rs_data;
        else if (i_jump)
            o_npc = w_j_target;
        else if (i_pcsrc)
            o_npc = w_br_target;
        else
            o_npc = i_pcplus4;
    end
endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch/execute sequencer: holds the PC, fetches over a ready
// handshake, holds the instruction during execution and applies the next PC.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_unit_if.master       imem,
    output logic        [31:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               pcsrc,
    input  logic               jump,
    input  logic               jr,
    input  logic signed [31:0] signimm,
    input  logic        [31:0] rs_data,
    output logic        [31:0] pc_out,
    output logic        [31:0] pcplus4,
    output logic               misaligned
);
    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_misaligned;
    logic [31:0]  w_npc;
    logic         w_fetch_fire;
    logic         w_exec_fire;
    logic         w_npc_bad;
    logic         w_req;
    logic         w_valid;

    assign w_fetch_fire = (r_state == FETCH) && imem.imem_ready;
    assign w_exec_fire  = (r_state == EXEC) && exec_done;
    assign w_npc_bad    = is_misaligned(w_npc);

    assign pc_out     = r_pc;
    assign pcplus4    = r_pc + 32'd4;
    assign instr      = r_instr;
    assign misaligned = r_misaligned;

    next_pc u_next_pc (
        .i_pcplus4 (pcplus4),
        .i_target  (r_instr[25:0]),
        .i_signimm (signimm),
        .i_rs_data (rs_data),
        .i_pcsrc   (pcsrc),
        .i_jump    (jump),
        .i_jr      (jr),
        .o_npc     (w_npc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= FETCH;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (imem.imem_ready) w_state_nxt = EXEC;
            EXEC:    if (exec_done) w_state_nxt = w_npc_bad ? HALT : FETCH;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_comb begin
        w_req   = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            FETCH:   w_req   = 1'b1;
            EXEC:    w_valid = 1'b1;
            default: ;
        endcase
    end

    // The request is withdrawn the moment reset asserts, abandoning the fetch.
    assign imem.imem_req  = w_req && reset_n;
    assign imem.imem_addr = r_pc;
    assign instr_valid    = w_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_misaligned <= 1'b0;
        end else begin
            if (w_fetch_fire)
                r_instr <= imem.imem_rdata;
            if (w_exec_fire) begin
                r_pc <= w_npc;
                if (w_npc_bad)
                    r_misaligned <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model plus directed vectors.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int PH_WAIT_MEM = 0;
    localparam int PH_RUN      = 1;
    localparam int PH_STOPPED  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exec_done = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] signimm = 32'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pcplus4;
    logic        misaligned;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .jr          (jr),
        .signimm     (signimm),
        .rs_data     (rs_data),
        .pc_out      (pc_out),
        .pcplus4     (pcplus4),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish act=timeout req=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one instruction is "wait for memory, then run until done".
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = 32'h0;
    int          m_phase = PH_WAIT_MEM;
    logic        m_mis = 1'b0;
    logic [31:0] m_target;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc    = RST_PC;
            m_instr = 32'h0;
            m_phase = PH_WAIT_MEM;
            m_mis   = 1'b0;
        end else if (m_phase == PH_WAIT_MEM) begin
            if (bus.imem_ready === 1'b1) begin
                m_instr = bus.imem_rdata;
                m_phase = PH_RUN;
            end
        end else if (m_phase == PH_RUN && exec_done === 1'b1) begin
            if (jr)
                m_target = rs_data;
            else if (jump)
                m_target = ((m_pc + 32'd4) & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            else if (pcsrc)
                m_target = m_pc + 32'd4 + (signimm * 32'd4);
            else
                m_target = m_pc + 32'd4;
            m_pc = m_target;
            if ((m_target % 32'd4) != 0) begin
                m_mis   = 1'b1;
                m_phase = PH_STOPPED;
            end else begin
                m_phase = PH_WAIT_MEM;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req",   {31'h0, bus.imem_req}, {31'h0, (m_phase == PH_WAIT_MEM) && reset_n});
            chk("m_addr",  bus.imem_addr, m_pc);
            chk("m_pc",    pc_out, m_pc);
            chk("m_pc4",   pcplus4, m_pc + 32'd4);
            chk("m_valid", {31'h0, instr_valid}, {31'h0, m_phase == PH_RUN});
            chk("m_instr", instr, m_instr);
            chk("m_mis",   {31'h0, misaligned}, {31'h0, m_mis});
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] word);
        bus.imem_rdata = word;
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
    endtask

    task automatic exec(input logic a_jr, input logic a_jump, input logic a_pcsrc,
                        input logic [31:0] a_imm, input logic [31:0] a_rs);
        exec_done = 1'b1;
        jr = a_jr; jump = a_jump; pcsrc = a_pcsrc;
        signimm = a_imm; rs_data = a_rs;
        tick();
        exec_done = 1'b0;
        jr = 1'b0; jump = 1'b0; pcsrc = 1'b0;
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        #1 chk_en = 1'b1;
        tick();
        tick();
        chk("rst_addr",  bus.imem_addr, 32'h0040_0000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_mis",   {31'h0, misaligned}, 32'h0);
        chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        reset_n = 1'b1;
        #1 chk("rel_req", {31'h0, bus.imem_req}, 32'h1);

        // Back-to-back instructions, ready and exec_done held high.
        bus.imem_ready = 1'b1; exec_done = 1'b1; bus.imem_rdata = 32'h1111_1111;
        tick();
        chk("seq_v1", {31'h0, instr_valid}, 32'h1);
        chk("seq_i1", instr, 32'h1111_1111);
        bus.imem_rdata = 32'h2222_2222;
        tick();
        chk("seq_a1", bus.imem_addr, 32'h0040_0004);
        chk("seq_v0", {31'h0, instr_valid}, 32'h0);
        tick();
        chk("seq_i2", instr, 32'h2222_2222);
        tick();
        chk("seq_a2", bus.imem_addr, 32'h0040_0008);
        bus.imem_ready = 1'b0; exec_done = 1'b0;

        // Memory wait states.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_req",  {31'h0, bus.imem_req}, 32'h1);
            chk("ws_addr", bus.imem_addr, 32'h0040_0008);
            chk("ws_val",  {31'h0, instr_valid}, 32'h0);
        end
        fetch(32'hDEAD_BEEF);
        chk("ws_instr", instr, 32'hDEAD_BEEF);
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h5555_5555;
        tick(); tick();
        chk("hold_instr", instr, 32'hDEAD_BEEF);
        chk("hold_req",   {31'h0, bus.imem_req}, 32'h0);
        bus.imem_ready = 1'b0;
        exec(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0100);
        chk("jr_100", bus.imem_addr, 32'h0000_0100);

        // Branches.
        fetch(32'h1000_FFFF);
        exec(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        chk("br_m1", bus.imem_addr, 32'h0000_0100);
        fetch(32'h1000_0004);
        exec(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0);
        chk("br_p4", bus.imem_addr, 32'h0000_0114);

        // Jump priority.
        fetch(32'h0000_0000);
        exec(1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0000);
        fetch(32'h0800_0040);
        exec(1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0);
        chk("j_win", bus.imem_addr, 32'h1000_0100);
        fetch(32'h0800_0040);
        exec(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_2000);
        chk("jr_win", bus.imem_addr, 32'h0000_2000);

        // PC wrap.
        fetch(32'h0);
        exec(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_p4", pcplus4, 32'h0000_0000);
        fetch(32'h0);
        exec(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc", bus.imem_addr, 32'h0000_0000);

        // Alignment fault and halt.
        fetch(32'h0);
        exec(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0102);
        chk("mis_flag", {31'h0, misaligned}, 32'h1);
        chk("mis_pc",   pc_out, 32'h0000_0102);
        bus.imem_ready = 1'b1; exec_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_req", {31'h0, bus.imem_req}, 32'h0);
            chk("halt_val", {31'h0, instr_valid}, 32'h0);
        end
        bus.imem_ready = 1'b0; exec_done = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("hrst_mis", {31'h0, misaligned}, 32'h0);
        chk("hrst_pc",  pc_out, 32'h0040_0000);
        tick();
        reset_n = 1'b1;
        #1 chk("hrst_req", {31'h0, bus.imem_req}, 32'h1);

        // Reset mid-fetch and mid-exec.
        fetch(32'h0);
        exec(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("mf_pc", pc_out, 32'h0040_0004);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mf_req", {31'h0, bus.imem_req}, 32'h0);
        chk("mf_pc0", pc_out, 32'h0040_0000);
        tick();
        reset_n = 1'b1;
        fetch(32'h0000_0123);
        reset_n = 1'b0;
        #1;
        chk("mx_val", {31'h0, instr_valid}, 32'h0);
        chk("mx_pc",  pc_out, 32'h0040_0000);
        chk("mx_ins", instr, 32'h0);
        tick();
        reset_n = 1'b1;
        tick(); tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage sitting directly upstream of the main controller/decoder.
- Holds the program counter and fetches from instruction memory through a ready handshake.
- Presents the instruction to the controller and datapath, then computes the next PC from the controller's pcsrc, jump and jr outputs.
- Converts the single-cycle core into a multi-cycle fetch/execute loop so the core tolerates instruction memory with wait states.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  reset, asynchronous and active-low.
imem_addr  output  32  instruction memory byte address; equals the current PC.
imem_req  output  1  fetch request; high only in FETCH state.
imem_rdata  input  32  instruction word; valid when imem_ready=1.
imem_ready  input  1  memory returns imem_rdata this cycle.
instr  output  32  registered instruction driven to controller op/funct and datapath.
instr_valid  output  1  instr is valid and executing.
exec_done  input  1  datapath has finished the current instruction; the next-PC controls are valid this cycle.
pcsrc  input  1  branch taken, from controller.
jump  input  1  j/jal, from controller.
jr  input  1  jump-register, from controller.
signimm  input  32  sign-extended immediate, from datapath.
rs_data  input  32  register rs value, for jr.
pc_out  output  32  current PC.
pcplus4  output  32  PC+4, used for the jal link value.
misaligned  output  1  sticky flag: a computed next PC had pc[1:0]!=0.

Behaviour:
- State machine, three states:
  - FETCH: issue a fetch and wait for memory.
  - EXEC: hold the instruction while the datapath executes.
  - HALT: stopped after a fault; exit only via reset.
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_PC, state=FETCH, instr=32'h0 (nop), instr_valid=0, misaligned=0.
  - imem_req is combinational from state, so it is 1 immediately after release.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1: instr<=imem_rdata, instr_valid<=1, state<=EXEC.
  - Otherwise hold with all registers unchanged; arbitrary wait states are allowed.
- EXEC:
  - imem_req=0; instr and instr_valid held stable.
  - On exec_done=1: pc<=npc, instr_valid<=0, state<=FETCH.
- Next-PC selection, priority jr > jump > pcsrc > sequential:
  - jr: npc=rs_data.
  - jump: npc={pcplus4[31:28], instr[25:0], 2'b00}.
  - pcsrc: npc=pcplus4 + (signimm<<2), 32-bit modulo.
  - default: npc=pcplus4.
- Arithmetic: pcplus4=pc+4 with 32-bit wrap, so 32'hFFFF_FFFC -> 32'h0000_0000.
- Alignment fault: if npc[1:0]!=0 at exec_done:
  - misaligned<=1, state<=HALT, pc still updated to npc.
  - HALT: imem_req=0, instr_valid=0.
- Ignored inputs:
  - exec_done outside EXEC.
  - imem_ready outside FETCH.
  - pcsrc/jump/jr while exec_done=0.
- Simultaneous events: jump and pcsrc both high resolve by priority (jump wins).
- Minimum latency: 2 cycles per instruction, with imem_ready in the first FETCH cycle and exec_done in the first EXEC cycle.
- Reset mid-fetch or mid-exec: the in-flight instruction is abandoned and no PC update occurs.
- pc_out and pcplus4 are combinational from the pc register.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {FETCH, EXEC, HALT}.
  - NOP_INSTR constant 32'h0.
  - DEFAULT_RESET_PC constant.
- One combinational sub-module next_pc:
  - Inputs: pcplus4, instr[25:0], signimm, rs_data, pcsrc, jump, jr.
  - Output: npc.
- FSM and registers live in fetch_unit.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, imem_ready=1, exec_done asserted each EXEC cycle -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008, and instr_valid toggles 1 every other cycle.
- imem_ready held low 3 cycles in FETCH -> imem_req stays 1, imem_addr stable, instr_valid=0 until the ready cycle; instr equals imem_rdata on the following cycle.
- pc=0x100, pcsrc=1, signimm=32'hFFFF_FFFF at exec_done -> next imem_addr=0x100. Separately, signimm=4 -> 0x114.
- pc=0x1000_0000, instr[25:0]=26'h0000040, jump=1 and pcsrc=1 together -> next imem_addr=0x1000_0100 (jump wins). jr=1 with rs_data=0x2000 also high -> 0x2000.
- jr=1, rs_data=32'h0000_0102 -> misaligned=1, state HALT, imem_req stays 0 for 10 cycles; reset_n low clears misaligned and restarts at RESET_PC.
- pc=32'hFFFF_FFFC, sequential -> next imem_addr=0. Separately, assert reset_n low mid-FETCH -> imem_req drops immediately and pc=RESET_PC.
